// File: rtl/alu_pkg.sv
// Shared opcode encoding for the ALU lane array.
package alu_pkg;
    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] OP_ADD   = 3'd0;
    localparam logic [SEL_W-1:0] OP_SUB   = 3'd1;
    localparam logic [SEL_W-1:0] OP_AND   = 3'd2;
    localparam logic [SEL_W-1:0] OP_OR    = 3'd3;
    localparam logic [SEL_W-1:0] OP_XOR   = 3'd4;
    localparam logic [SEL_W-1:0] OP_ACC   = 3'd5;
    localparam logic [SEL_W-1:0] OP_LDA   = 3'd6;
    localparam logic [SEL_W-1:0] OP_PASSB = 3'd7;
endpackage

// File: rtl/alu_lane.sv
// Combinational WIDTH-bit op unit for one lane; the accumulator register lives in the top.
module alu_lane
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic [WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic [WIDTH-1:0] acc_next_o
);
    // Bit WIDTH of the extended result is the carry/borrow for every opcode.
    logic [WIDTH:0] ext;

    always_comb begin
        ext        = '0;
        acc_next_o = acc_i;
        case (sel_i)
            OP_ADD: ext = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB: ext = {1'b0, a_i} - {1'b0, b_i};
            OP_AND: ext = {1'b0, a_i & b_i};
            OP_OR:  ext = {1'b0, a_i | b_i};
            OP_XOR: ext = {1'b0, a_i ^ b_i};
            OP_ACC: begin
                ext        = {1'b0, acc_i} + {1'b0, a_i};
                acc_next_o = ext[WIDTH-1:0];
            end
            OP_LDA: begin
                ext        = {1'b0, a_i};
                acc_next_o = a_i;
            end
            default: ext = {1'b0, b_i};
        endcase
    end

    assign res_o   = ext[WIDTH-1:0];
    assign carry_o = ext[WIDTH];
endmodule

// File: rtl/alu_array_pipe.sv
// CHANNELS-lane ALU behind a two-stage valid/ready pipeline with per-lane accumulators
// and a cross-lane XOR reduction of the results.
module alu_array_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] a_i,
    input  logic [CHANNELS*WIDTH-1:0] b_i,
    input  logic [CHANNELS*SEL_W-1:0] sel_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] alu_o,
    output logic [CHANNELS-1:0]       carry_o,
    output logic [WIDTH-1:0]          xor_o,
    output logic                      par_o
);
    logic                               s1_valid_q, s2_valid_q;
    logic [CHANNELS-1:0][WIDTH-1:0]     a_q, b_q, acc_q, alu_q;
    logic [CHANNELS-1:0][SEL_W-1:0]     sel_q;
    logic [CHANNELS-1:0]                carry_q;
    logic [WIDTH-1:0]                   xor_q;
    logic                               par_q;

    logic [CHANNELS-1:0][WIDTH-1:0]     res_d, acc_d;
    logic [CHANNELS-1:0]                carry_d;
    logic [WIDTH-1:0]                   xor_d;
    logic                               s1_adv, s2_adv, accept, xfer;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && s1_adv;
    // Accumulators move only when a bundle actually crosses into stage 2.
    assign xfer     = s1_valid_q && s2_adv;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        alu_lane #(.WIDTH(WIDTH)) u_lane (
            .a_i       (a_q[k]),
            .b_i       (b_q[k]),
            .sel_i     (sel_q[k]),
            .acc_i     (acc_q[k]),
            .res_o     (res_d[k]),
            .carry_o   (carry_d[k]),
            .acc_next_o(acc_d[k])
        );
    end

    always_comb begin
        xor_d = '0;
        for (int k = 0; k < CHANNELS; k++) xor_d = xor_d ^ res_d[k];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
        end else begin
            if (s1_adv) s1_valid_q <= in_valid;
            if (accept) begin
                a_q   <= a_i;
                b_q   <= b_i;
                sel_q <= sel_i;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            s2_valid_q <= 1'b0;
            alu_q      <= '0;
            carry_q    <= '0;
            xor_q      <= '0;
            par_q      <= 1'b0;
            acc_q      <= '0;
        end else begin
            if (s2_adv) s2_valid_q <= s1_valid_q;
            if (xfer) begin
                alu_q   <= res_d;
                carry_q <= carry_d;
                xor_q   <= xor_d;
                par_q   <= ^xor_d;
                acc_q   <= acc_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign alu_o     = alu_q;
    assign carry_o   = carry_q;
    assign xor_o     = xor_q;
    assign par_o     = par_q;
endmodule

// File: tb/tb_alu_array_pipe.sv
// Scoreboard bench for alu_array_pipe at WIDTH=8, CHANNELS=2.
module tb_alu_array_pipe;
    localparam int W = 8;
    localparam int C = 2;

    logic          clk = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [C*W-1:0] a_i = '0, b_i = '0;
    logic [C*3-1:0] sel_i = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [C*W-1:0] alu_o;
    logic [C-1:0]  carry_o;
    logic [W-1:0]  xor_o;
    logic          par_o;

    alu_array_pipe #(.WIDTH(W), .CHANNELS(C)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (wb_rst_i),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_i      (a_i),
        .b_i      (b_i),
        .sel_i    (sel_i),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alu_o    (alu_o),
        .carry_o  (carry_o),
        .xor_o    (xor_o),
        .par_o    (par_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [C*W-1:0] alu;
        logic [C-1:0]   carry;
        logic [W-1:0]   x;
        logic           p;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [W-1:0] macc [C];
    int          n_tests = 0, n_fail = 0;
    int          cyc = 0, pops = 0, last_pop = -10, run_len = 0;
    logic        hold_v = 1'b0;
    logic [C*W+C+W:0] held;

    // Reference model: computes one bundle and advances the model accumulators.
    task automatic model(input logic [C*W-1:0] a, input logic [C*W-1:0] b, input logic [C*3-1:0] sel,
                         output logic [C*W-1:0] r, output logic [C-1:0] c);
        for (int l = 0; l < C; l++) begin
            logic [W-1:0] av, bv;
            logic [W:0]   t;
            av = a[l*W +: W];
            bv = b[l*W +: W];
            case (sel[l*3 +: 3])
                3'd0: t = {1'b0, av} + {1'b0, bv};
                3'd1: t = {1'b0, av} - {1'b0, bv};
                3'd2: t = {1'b0, av & bv};
                3'd3: t = {1'b0, av | bv};
                3'd4: t = {1'b0, av ^ bv};
                3'd5: begin t = {1'b0, macc[l]} + {1'b0, av}; macc[l] = t[W-1:0]; end
                3'd6: begin t = {1'b0, av}; macc[l] = av; end
                default: t = {1'b0, bv};
            endcase
            r[l*W +: W] = t[W-1:0];
            c[l]        = t[W];
        end
    endtask

    task automatic push_exp(input logic [C*W-1:0] r, input logic [C-1:0] c);
        exp_t e;
        e.alu   = r;
        e.carry = c;
        e.x     = '0;
        for (int l = 0; l < C; l++) e.x = e.x ^ r[l*W +: W];
        e.p = ^e.x;
        sb.push_back(e);
    endtask

    // Called just after a posedge; returns just after the posedge that accepted the bundle.
    // Directed tests supply their own expected values; the model still tracks the accumulators.
    task automatic send(input logic [C*W-1:0] a, input logic [C*W-1:0] b, input logic [C*3-1:0] sel,
                        input logic use_exp, input logic [C*W-1:0] ealu, input logic [C-1:0] ecar);
        int tries;
        logic [C*W-1:0] r;
        logic [C-1:0]   c;
        tries = 0;
        in_valid = 1'b1; a_i = a; b_i = b; sel_i = sel;
        @(negedge clk);
        while (!in_ready && tries < 50) begin
            a_i = $urandom; b_i = $urandom; sel_i = $urandom;
            @(posedge clk); #1;
            a_i = a; b_i = b; sel_i = sel;
            @(negedge clk);
            tries++;
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end else begin
            model(a, b, sel, r, c);
            if (use_exp) push_exp(ealu, ecar);
            else         push_exp(r, c);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain pending=%0d required 0", name, sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if ({out_valid, alu_o, carry_o, xor_o, par_o} !== '0) begin
            n_fail++;
            $display("FAIL %s out_valid=%b alu_o=%h carry_o=%b xor_o=%h par_o=%b required all 0",
                     name, out_valid, alu_o, carry_o, xor_o, par_o);
        end
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); wb_rst_i = 1'b0;
        #1;
        check_zero("reset_outputs");
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got=%b required 1", in_ready);
        end
        for (int l = 0; l < C; l++) macc[l] = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub();
        send({8'h05, 8'hF0}, {8'h07, 8'h20}, {3'd1, 3'd0}, 1'b1, {8'hFE, 8'h10}, 2'b11);
        wait_drain("add_sub");
    endtask

    task automatic test_accumulate();
        send({8'h00, 8'h80}, {8'h42, 8'h00}, {3'd7, 3'd6}, 1'b1, {8'h42, 8'h80}, 2'b00);
        send({8'h00, 8'h90}, {8'h43, 8'h00}, {3'd7, 3'd5}, 1'b1, {8'h43, 8'h10}, 2'b01);
        send({8'h00, 8'h01}, {8'h44, 8'h00}, {3'd7, 3'd5}, 1'b1, {8'h44, 8'h11}, 2'b00);
        wait_drain("accumulate");
    endtask

    task automatic test_backpressure();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [2:0] op0;
                    op0 = 3'($urandom_range(0, 4));
                    send($urandom, $urandom, {3'd5, op0}, 1'b0, '0, '0);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #2;
                n_tests++;
                if (in_ready !== 1'b0 || sb.size() != 2) begin
                    n_fail++;
                    $display("FAIL stall_fill in_ready=%b buffered=%0d required 0 and 2", in_ready, sb.size());
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain("backpressure");
    endtask

    task automatic test_logic_ops();
        send({8'h3C, 8'hA5}, {8'hA5, 8'h3C}, {3'd2, 3'd2}, 1'b1, {8'h24, 8'h24}, 2'b00);
        send({8'h3C, 8'hA5}, {8'hA5, 8'h3C}, {3'd3, 3'd3}, 1'b1, {8'hBD, 8'hBD}, 2'b00);
        send({8'h3C, 8'hA5}, {8'hA5, 8'h3C}, {3'd4, 3'd4}, 1'b1, {8'h99, 8'h99}, 2'b00);
        send({8'h3C, 8'hA5}, {8'hA5, 8'h3C}, {3'd7, 3'd7}, 1'b1, {8'hA5, 8'h3C}, 2'b00);
        wait_drain("logic_ops");
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        send({8'h77, 8'h77}, '0, {3'd6, 3'd6}, 1'b1, {8'h77, 8'h77}, 2'b00);
        send({8'h66, 8'h66}, '0, {3'd6, 3'd6}, 1'b1, {8'h66, 8'h66}, 2'b00);
        #2 wb_rst_i = 1'b1;
        #1;
        check_zero("midreset_outputs");
        sb.delete();
        for (int l = 0; l < C; l++) macc[l] = '0;
        @(negedge clk);
        wb_rst_i = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send({8'h05, 8'h03}, '0, {3'd5, 3'd5}, 1'b1, {8'h05, 8'h03}, 2'b00);
        wait_drain("midreset_acc");
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pops;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_in_ready idx=%0d got=%b required 1", i, in_ready);
            end
            send($urandom, $urandom, 6'($urandom), 1'b0, '0, '0);
        end
        wait_drain("back_to_back");
        n_tests++;
        if (pops - p0 != 10 || run_len != 10) begin
            n_fail++;
            $display("FAIL b2b_rate results=%0d run=%0d required 10 and 10", pops - p0, run_len);
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (wb_rst_i || !out_valid) hold_v = 1'b0;
                else if (out_ready) begin
                    hold_v = 1'b0;
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output alu_o=%h required none", alu_o);
                    end else begin
                        mon_e = sb.pop_front();
                        if ({alu_o, carry_o, xor_o, par_o} !== {mon_e.alu, mon_e.carry, mon_e.x, mon_e.p}) begin
                            n_fail++;
                            $display("FAIL result alu_o=%h carry_o=%b xor_o=%h par_o=%b required %h %b %h %b",
                                     alu_o, carry_o, xor_o, par_o, mon_e.alu, mon_e.carry, mon_e.x, mon_e.p);
                        end
                        pops++;
                        run_len  = (cyc == last_pop + 1) ? run_len + 1 : 1;
                        last_pop = cyc;
                    end
                end else begin
                    if (hold_v) begin
                        n_tests++;
                        if ({alu_o, carry_o, xor_o, par_o} !== held) begin
                            n_fail++;
                            $display("FAIL stall_hold got=%h required %h", {alu_o, carry_o, xor_o, par_o}, held);
                        end
                    end
                    held   = {alu_o, carry_o, xor_o, par_o};
                    hold_v = 1'b1;
                end
            end
        join_none

        test_reset();
        test_add_sub();
        test_accumulate();
        test_backpressure();
        test_logic_ops();
        test_reset_midstream();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
